// File: rtl/vga_pkg.sv
// Shared 800x600@60 VGA timing constants plus the types used by the sync-timing
// monitor (state encoding, error-flag bit positions, counter width).
package vga_pkg;

    localparam int HOR_ADDR_TIME  = 800;
    localparam int HOR_SYNC_START = 840;
    localparam int HOR_SYNC_TIME  = 128;
    localparam int HOR_TOTAL_TIME = 1055;
    localparam int VER_ADDR_TIME  = 600;
    localparam int VER_SYNC_START = 601;
    localparam int VER_SYNC_TIME  = 4;
    localparam int VER_TOTAL_TIME = 627;

    // The *_TOTAL_TIME values are last-count values; the totals are counts of clocks/lines.
    localparam int HOR_TOTAL = HOR_TOTAL_TIME + 1;
    localparam int VER_TOTAL = VER_TOTAL_TIME + 1;

    localparam int CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        HSYNCED = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    localparam int ERR_W    = 4;
    localparam int ERR_HPER = 0;
    localparam int ERR_HWID = 1;
    localparam int ERR_VPOS = 2;
    localparam int ERR_VWID = 3;
    typedef logic [ERR_W-1:0] err_t;

    localparam int FRAME_CNT_W = 16;
    localparam int ERR_CNT_W   = 8;

endpackage

// File: rtl/vga_timing_monitor_if.sv
// Bus between a VGA sync source / consumer (master) and the timing monitor (slave):
// observed syncs and flag clear in, recovered raster position, lock and errors out.
interface vga_timing_monitor_if;
    import vga_pkg::*;

    logic                   hsync_in;
    logic                   vsync_in;
    logic                   err_clr;
    cnt_t                   hcount_out;
    cnt_t                   vcount_out;
    logic                   hblnk_out;
    logic                   vblnk_out;
    logic                   locked;
    logic                   frame_start;
    logic                   err_pulse;
    err_t                   err_flags;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [ERR_CNT_W-1:0]   err_cnt;

    modport master (
        output hsync_in, vsync_in, err_clr,
        input  hcount_out, vcount_out, hblnk_out, vblnk_out,
        input  locked, frame_start, err_pulse, err_flags, frame_cnt, err_cnt
    );

    modport slave (
        input  hsync_in, vsync_in, err_clr,
        output hcount_out, vcount_out, hblnk_out, vblnk_out,
        output locked, frame_start, err_pulse, err_flags, frame_cnt, err_cnt
    );

endinterface

// File: rtl/vga_timing_monitor_sync_edge_det.sv
// sync_edge_det: one-register sampling stage for a sync line with combinational
// rise/fall detection against the previous sample.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic rise,
    output logic fall
);

    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
        end else begin
            // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
            sync_q <= sync_in;
        end
    end

    assign rise = sync_in & ~sync_q;
    assign fall = ~sync_in & sync_q;

endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: recovers raster position from observed hsync/vsync, declares
// lock and flags timing violations. Statistics counters exist only with VGA_MON_STATS_EN.
module vga_timing_monitor
    import vga_pkg::*;
#(
    parameter int H_TOTAL      = HOR_TOTAL,
    parameter int H_ACTIVE     = HOR_ADDR_TIME,
    parameter int H_SYNC_START = HOR_SYNC_START,
    parameter int H_SYNC_TIME  = HOR_SYNC_TIME,
    parameter int V_TOTAL      = VER_TOTAL,
    parameter int V_ACTIVE     = VER_ADDR_TIME,
    parameter int V_SYNC_START = VER_SYNC_START,
    parameter int V_SYNC_TIME  = VER_SYNC_TIME
) (
    input  logic clk,
    input  logic rst_n,
    vga_timing_monitor_if.slave bus
);

    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_RISE = cnt_t'(H_SYNC_START);
    localparam cnt_t H_FALL = cnt_t'(H_SYNC_START + H_SYNC_TIME);
    localparam cnt_t V_RISE = cnt_t'(V_SYNC_START);
    localparam cnt_t V_FALL = cnt_t'(V_SYNC_START + V_SYNC_TIME);
    localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);

    logic hs_rise;
    logic hs_fall;
    logic vs_rise;
    logic vs_fall;

    sync_edge_det u_hs_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync_in (bus.hsync_in),
        .rise    (hs_rise),
        .fall    (hs_fall)
    );

    sync_edge_det u_vs_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync_in (bus.vsync_in),
        .rise    (vs_rise),
        .fall    (vs_fall)
    );

    mon_state_t state_q;
    cnt_t       hcount_q;
    cnt_t       vcount_q;
    logic       locked_q;
    logic       frame_start_q;
    logic       err_pulse_q;
    err_t       err_flags_q;
    logic       hblnk_q;
    logic       vblnk_q;

    logic       h_wrap;
    cnt_t       h_next;
    cnt_t       v_next;
    err_t       err_vec;
    logic       h_err;
    logic       v_err;
    logic       drop;
    logic       lock_err;
    mon_state_t state_d;
    cnt_t       hcount_d;
    cnt_t       vcount_d;
    err_t       err_flags_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block leaves a latch.
        h_wrap      = (hcount_q == H_LAST);
        h_next      = h_wrap ? '0 : hcount_q + 1'b1;
        v_next      = vcount_q;
        err_vec     = '0;
        drop        = 1'b0;
        lock_err    = 1'b0;
        state_d     = state_q;
        hcount_d    = h_next;
        vcount_d    = v_next;

        if (h_wrap) begin
            v_next   = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            vcount_d = v_next;
        end

        // A rise anywhere but the predicted start, or a predicted start without a rise.
        err_vec[ERR_HPER] = hs_rise ^ (h_next == H_RISE);
        err_vec[ERR_HWID] = hs_fall && (h_next != H_FALL);
        err_vec[ERR_VPOS] = vs_rise && ((v_next != V_RISE) || (h_next != '0));
        err_vec[ERR_VWID] = vs_fall && (v_next != V_FALL);

        h_err = err_vec[ERR_HPER] | err_vec[ERR_HWID];
        v_err = err_vec[ERR_VPOS] | err_vec[ERR_VWID];

        case (state_q)
            SEARCH: begin
                drop = 1'b1;
            end
            HSYNCED: begin
                drop = h_err;
                if (!h_err && vs_rise && (h_next == '0)) begin
                    state_d  = LOCKED;
                    vcount_d = V_RISE;
                end
            end
            LOCKED: begin
                drop     = h_err | v_err;
                lock_err = h_err | v_err;
            end
            default: begin
                drop = 1'b1;
            end
        endcase

        // Losing sync re-evaluates as SEARCH on the same edge, so a misplaced hsync
        // rise immediately becomes the new horizontal reference.
        if (drop) begin
            vcount_d = '0;
            if (hs_rise) begin
                state_d  = HSYNCED;
                hcount_d = H_RISE;
            end else begin
                state_d  = SEARCH;
                hcount_d = '0;
            end
        end

        // A fresh error flag overrides a simultaneous clear.
        err_flags_d = (bus.err_clr ? err_t'('0) : err_flags_q) | (lock_err ? err_vec : err_t'('0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= SEARCH;
            hcount_q      <= '0;
            vcount_q      <= '0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_flags_q   <= '0;
            hblnk_q       <= 1'b1;
            vblnk_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            locked_q      <= (state_d == LOCKED);
            frame_start_q <= (state_d == LOCKED) && (hcount_d == '0) && (vcount_d == '0);
            err_pulse_q   <= lock_err;
            err_flags_q   <= err_flags_d;
            hblnk_q       <= (state_d != LOCKED) || (hcount_d >= H_ACT);
            vblnk_q       <= (state_d != LOCKED) || (vcount_d >= V_ACT);
        end
    end

    assign bus.hcount_out  = hcount_q;
    assign bus.vcount_out  = vcount_q;
    assign bus.hblnk_out   = hblnk_q;
    assign bus.vblnk_out   = vblnk_q;
    assign bus.locked      = locked_q;
    assign bus.frame_start = frame_start_q;
    assign bus.err_pulse   = err_pulse_q;
    assign bus.err_flags   = err_flags_q;

`ifdef VGA_MON_STATS_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    // Frame count wraps naturally; error count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (frame_start_q) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            if (err_pulse_q && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
    assign bus.err_cnt   = err_cnt_q;
`else
    assign bus.frame_cnt = '0;
    assign bus.err_cnt   = '0;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Scoreboard bench for vga_timing_monitor on a shrunken raster: a frame-position
// reference model predicts every output cycle; a monitor pops and compares.
`timescale 1ns/1ps
module tb_vga_timing_monitor;
    import vga_pkg::*;

    localparam int HT = 16, HA = 10, HSS = 11, HSW = 3;
    localparam int VT = 9,  VA = 5,  VSS = 6,  VSW = 2;
    localparam int FRAME = HT * VT;
    localparam int M_SEARCH = 0, M_HSYNC = 1, M_LOCK = 2;
    localparam int MAX_FAIL = 30;
`ifdef VGA_MON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        int       h;
        int       v;
        bit       hb;
        bit       vb;
        bit       lk;
        bit       fs;
        bit       ep;
        bit [3:0] ef;
        int       fc;
        int       ec;
    } exp_t;

    logic clk;
    logic rst_n;
    vga_timing_monitor_if mon_if ();

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_TIME(HSW),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_TIME(VSW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mon_if)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   abort = 1'b0;

    // Reference model: the recovered position is one linear index into the frame.
    int       m_mode, m_pos, m_fc, m_ec;
    bit       m_hs_p, m_vs_p, m_fs, m_ep;
    bit [3:0] m_flags;

    task automatic model_step(input bit r, input bit hs, input bit vs, input bit clr, output exp_t e);
        bit hr, hf, vr, vf, hbad, vbad, drop;
        int np, hn, vn;
        bit [3:0] errs;
        if (!r) begin
            m_mode = M_SEARCH; m_pos = 0; m_hs_p = 0; m_vs_p = 0;
            m_flags = 0; m_fc = 0; m_ec = 0; m_fs = 0; m_ep = 0;
        end else begin
            hr = hs && !m_hs_p;  hf = !hs && m_hs_p;
            vr = vs && !m_vs_p;  vf = !vs && m_vs_p;
            np = (m_pos + 1) % FRAME;
            hn = np % HT;
            vn = np / HT;
            errs[0] = (hr != (hn == HSS));
            errs[1] = hf && (hn != HSS + HSW);
            errs[2] = vr && !(vn == VSS && hn == 0);
            errs[3] = vf && (vn != VSS + VSW);
            hbad = errs[0] || errs[1];
            vbad = errs[2] || errs[3];
            if (STATS) begin
                if (m_fs) m_fc = (m_fc + 1) % 65536;
                if (m_ep && m_ec < 255) m_ec++;
            end
            drop = (m_mode == M_SEARCH) || hbad || (m_mode == M_LOCK && vbad);
            if (clr) m_flags = 0;
            m_ep = (m_mode == M_LOCK) && drop;
            if (m_ep) m_flags |= errs;
            if (drop) begin
                if (hr) begin m_mode = M_HSYNC; m_pos = HSS; end
                else    begin m_mode = M_SEARCH; m_pos = 0; end
            end else if (m_mode == M_HSYNC && vr && hn == 0) begin
                m_mode = M_LOCK;
                m_pos  = VSS * HT;
            end else begin
                m_pos = np;
            end
            m_hs_p = hs;
            m_vs_p = vs;
        end
        e.h  = m_pos % HT;
        e.v  = m_pos / HT;
        e.lk = (m_mode == M_LOCK);
        e.hb = !e.lk || e.h >= HA;
        e.vb = !e.lk || e.v >= VA;
        e.fs = e.lk && m_pos == 0;
        e.ep = m_ep;
        e.ef = m_flags;
        e.fc = m_fc;
        e.ec = m_ec;
        m_fs = e.fs;
    endtask

    task automatic apply(input bit r, input bit hs, input bit vs, input bit clr);
        exp_t e;
        @(negedge clk);
        rst_n           = r;
        mon_if.hsync_in = hs;
        mon_if.vsync_in = vs;
        mon_if.err_clr  = clr;
        model_step(r, hs, vs, clr, e);
        sb.push_back(e);
    endtask

    // kind: 0 clean, 1 early hsync, 2 short hsync, 3 long hsync, 4 early vsync,
    // 5 short vsync, 6 hsync glitch, 7 err_clr pulse, 8 reset pulse, 9 syncs held.
    task automatic drive_frame(input int kind, input int line, input int col, input bit rnd_clr);
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                int hlo, hhi, vlo, vhi;
                bit hs, vs, clr, r, here;
                hlo = HSS; hhi = HSS + HSW; vlo = VSS; vhi = VSS + VSW;
                here = (v == line) && (h == col);
                if (v == line) begin
                    if (kind == 1) begin hlo--; hhi--; end
                    if (kind == 2) hhi--;
                    if (kind == 3) hhi++;
                end
                if (kind == 4) vlo--;
                if (kind == 5) vhi--;
                hs = (h >= hlo) && (h < hhi);
                vs = (v >= vlo) && (v < vhi);
                if (kind == 6 && here) hs = !hs;
                if (kind == 9) begin hs = line[0]; vs = col[0]; end
                r   = !(kind == 8 && here);
                clr = (kind == 7 && here) || (rnd_clr && $urandom_range(63) == 0);
                apply(r, hs, vs, clr);
            end
        end
    endtask

    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                a.h  = int'(mon_if.hcount_out);
                a.v  = int'(mon_if.vcount_out);
                a.hb = mon_if.hblnk_out;
                a.vb = mon_if.vblnk_out;
                a.lk = mon_if.locked;
                a.fs = mon_if.frame_start;
                a.ep = mon_if.err_pulse;
                a.ef = mon_if.err_flags;
                a.fc = int'(mon_if.frame_cnt);
                a.ec = int'(mon_if.err_cnt);
                checks++;
                if ($isunknown({mon_if.hcount_out, mon_if.vcount_out, mon_if.err_flags}) || a != e) begin
                    failures++;
                    $display("FAIL outputs@cycle%0d got h=%0d v=%0d hb=%0b vb=%0b lk=%0b fs=%0b ep=%0b ef=%b fc=%0d ec=%0d want h=%0d v=%0d hb=%0b vb=%0b lk=%0b fs=%0b ep=%0b ef=%b fc=%0d ec=%0d",
                             cyc, a.h, a.v, a.hb, a.vb, a.lk, a.fs, a.ep, a.ef, a.fc, a.ec,
                             e.h, e.v, e.hb, e.vb, e.lk, e.fs, e.ep, e.ef, e.fc, e.ec);
                    if (failures >= MAX_FAIL) abort = 1'b1;
                end
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        mon_if.hsync_in = 1'b0;
        mon_if.vsync_in = 1'b0;
        mon_if.err_clr  = 1'b0;
        repeat (3) apply(1'b0, 1'b0, 1'b0, 1'b0);

        // Directed: clean lock, each violation class, flag clear, mid-frame reset.
        for (int i = 0; i < 3 && !abort; i++) drive_frame(0, 0, 0, 1'b0);
        if (!abort) drive_frame(1, 2, 0, 1'b0);
        if (!abort) drive_frame(0, 0, 0, 1'b0);
        if (!abort) drive_frame(2, 3, 0, 1'b0);
        if (!abort) drive_frame(0, 0, 0, 1'b0);
        if (!abort) drive_frame(4, 0, 0, 1'b0);
        if (!abort) drive_frame(7, 7, 3, 1'b0);
        if (!abort) drive_frame(8, 4, 6, 1'b0);
        if (!abort) drive_frame(9, 0, 0, 1'b0);
        for (int i = 0; i < 2 && !abort; i++) drive_frame(0, 0, 0, 1'b0);

        // Random mix of every disturbance with background flag clears.
        for (int i = 0; i < 40 && !abort; i++) begin
            int k;
            k = ($urandom_range(99) < 15) ? 0 : 1 + int'($urandom_range(8));
            drive_frame(k, int'($urandom_range(VT - 1)), int'($urandom_range(HT - 1)), 1'b1);
        end

        // Long run of locked-frame H errors with no reset, driving err_cnt to saturation.
        for (int i = 0; i < 300 && !abort; i++) begin
            int k;
            case ($urandom_range(3))
                0:       k = 1;
                1:       k = 2;
                2:       k = 3;
                default: k = 6;
            endcase
            drive_frame(k, int'($urandom_range(4)), int'($urandom_range(HT - 1)), 1'b0);
        end
        for (int i = 0; i < 2 && !abort; i++) drive_frame(0, 0, 0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0 && !abort) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
